present_enc: RTL and testbench

PRESENT_ENC -- requirements
Module: present_enc

---
 rtl/present_pkg.sv | 34 +++
 rtl/present_enc_if.sv | 22 ++
 rtl/present_enc_sbox.sv | 29 ++
 rtl/present_enc.sv | 121 ++++++++++++
 tb/tb_present_enc.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared constants, types and reference vectors for the PRESENT-80 encryptor.
package present_pkg;

  localparam int ROUNDS  = 31;
  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int RND_W   = 5;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_e;

  // P-layer: bit i of the S-layer output lands on bit p_pos(i) of the next state.
  function automatic int p_pos(input int i);
    return (i == BLOCK_W - 1) ? i : (i * 16) % (BLOCK_W - 1);
  endfunction

  typedef struct packed {
    logic [BLOCK_W-1:0] pt;
    logic [KEY_W-1:0]   key;
    logic [BLOCK_W-1:0] ct;
  } test_vec_t;

  localparam test_vec_t TEST_VEC [4] = '{
    '{pt: 64'h0000000000000000, key: 80'h00000000000000000000, ct: 64'h5579C1387B228445},
    '{pt: 64'h0000000000000000, key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'hE72C46C0F5945049},
    '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'h00000000000000000000, ct: 64'hA112FFC72F68417B},
    '{pt: 64'hFFFFFFFFFFFFFFFF, key: 80'hFFFFFFFFFFFFFFFFFFFF, ct: 64'h3333DCD3213210D2}
  };

endpackage

// File: rtl/present_enc_if.sv
// Request/result bundle between a block requester (master) and present_enc (slave).
interface present_enc_if;
  import present_pkg::*;

  logic               start;
  logic [BLOCK_W-1:0] plaintext;
  logic [KEY_W-1:0]   key;
  logic               busy;
  logic               done;
  logic [BLOCK_W-1:0] ciphertext;

  modport master (
    output start, plaintext, key,
    input  busy, done, ciphertext
  );

  modport slave (
    input  start, plaintext, key,
    output busy, done, ciphertext
  );

endinterface

// File: rtl/present_enc_sbox.sv
// 4-bit PRESENT S-box; the nibble is read as a value with its MSB as the top bit.
module sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);

  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
    endcase
  end

endmodule

// File: rtl/present_enc.sv
// Iterative PRESENT-80 encryptor: one round per clock, 31 rounds plus final whitening.
module present_enc
  import present_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  present_enc_if.slave bus
);

  fsm_e               fsm_q;
  fsm_e               fsm_d;
  logic [BLOCK_W-1:0] state_q;
  logic [KEY_W-1:0]   keyreg_q;
  logic [RND_W-1:0]   rnd_q;
  logic               done_q;
  logic [BLOCK_W-1:0] ct_q;

  logic [BLOCK_W-1:0] add_key;
  logic [BLOCK_W-1:0] sbox_out;
  logic [BLOCK_W-1:0] state_nxt;
  logic [KEY_W-1:0]   key_rot;
  logic [KEY_W-1:0]   key_nxt;
  logic [3:0]         key_nib;

  logic               busy;
  logic               load;
  logic               last;

  // ---------------- round datapath (purely combinational) ----------------
  assign add_key = state_q ^ keyreg_q[KEY_W-1:KEY_W-BLOCK_W];

  for (genvar i = 0; i < BLOCK_W / 4; i++) begin : g_sbox
    sbox u_sbox (
      .x (add_key[4*i+3:4*i]),
      .y (sbox_out[4*i+3:4*i])
    );
  end

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_player
    assign state_nxt[p_pos(i)] = sbox_out[i];
  end

  // Rotating left by 61 is the same as rotating right by 19.
  assign key_rot = {keyreg_q[18:0], keyreg_q[KEY_W-1:19]};

  sbox u_key_sbox (
    .x (key_rot[79:76]),
    .y (key_nib)
  );

  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
    key_nxt         = key_rot;
    key_nxt[79:76]  = key_nib;
    key_nxt[19:15]  = key_rot[19:15] ^ rnd_q;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (bus.start)         fsm_d = ST_RUN;
      ST_RUN:  if (rnd_q == LAST_RND) fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    last = 1'b0;
    case (fsm_q)
      ST_IDLE: load = bus.start;
      ST_RUN: begin
        busy = 1'b1;
        last = (rnd_q == LAST_RND);
      end
      default: ;
    endcase
  end

  // ---------------- cipher state, key register, result ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= '0;
      keyreg_q <= '0;
      rnd_q    <= '0;
      done_q   <= 1'b0;
      ct_q     <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignment so every flop sees pre-edge values.
      done_q <= 1'b0;
      if (load) begin
        state_q  <= bus.plaintext;
        keyreg_q <= bus.key;
        rnd_q    <= RND_W'(1);
      end else if (busy) begin
        state_q  <= state_nxt;
        keyreg_q <= key_nxt;
        rnd_q    <= last ? '0 : rnd_q + RND_W'(1);
        if (last) begin
          ct_q   <= state_nxt ^ key_nxt[KEY_W-1:KEY_W-BLOCK_W];
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done_q;
  assign bus.ciphertext = ct_q;

endmodule

// File: tb/tb_present_enc.sv
// Self-checking bench for present_enc: whole-cipher reference function plus a block-level timing model.
module tb_present_enc;
  import present_pkg::*;

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  localparam logic [63:0] LIT_PT  [4] = '{64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
  localparam logic [79:0] LIT_KEY [4] = '{80'h0, 80'hFFFFFFFFFFFFFFFFFFFF, 80'h0, 80'hFFFFFFFFFFFFFFFFFFFF};
  localparam logic [63:0] LIT_CT  [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                                          64'hA112FFC72F68417B, 64'h3333DCD3213210D2};

  logic clk = 1'b0;
  logic rst = 1'b0;

  present_enc_if bus ();

  present_enc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [63:0] m_ct   = '0;
  logic [63:0] m_res  = '0;
  int          m_left = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole PRESENT-80 encryption: derive all 32 round keys, then 31 rounds and whitening.
  function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0]  k;
    logic [159:0] kk;
    logic [63:0]  rk [33];
    logic [63:0]  s;
    logic [63:0]  t;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k[79:16];
      kk = {k, k} >> 19;
      k = kk[79:0];
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rk[r];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
      s = t;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
    end
    return s ^ rk[32];
  endfunction

  // Block-level timing model: a block accepted at one edge completes 31 edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ct   = '0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_ct   = m_res;
        end
      end else if (bus.start) begin
        m_busy = 1'b1;
        m_left = ROUNDS;
        m_res  = present80(bus.plaintext, bus.key);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 80'(bus.busy), 80'(m_busy));
      check("done", 80'(bus.done), 80'(m_done));
      check("ciphertext", 80'(bus.ciphertext), 80'(m_ct));
    end
  end

  task automatic drive(input bit s, input logic [63:0] p, input logic [79:0] k);
    bus.start     = s;
    bus.plaintext = p;
    bus.key       = k;
  endtask

  task automatic wait_done(input bit scramble, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (scramble) drive(1'b0, {$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
    end while (!bus.done && cycles < 40);
    check("done_seen", 80'(bus.done), 80'(1));
  endtask

  task automatic run_block(input logic [63:0] p, input logic [79:0] k, input logic [63:0] exp_ct);
    int cyc;
    drive(1'b1, p, k);
    @(negedge clk);
    drive(1'b0, ~p, ~k);
    wait_done(1'b1, cyc);
    check("latency", 80'(cyc), 80'(ROUNDS));
    check("vector_ct", 80'(bus.ciphertext), 80'(exp_ct));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cyc;
    int n_rand_done;

    drive(1'b0, '0, '0);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_done", 80'(bus.done), 80'(0));
    check("rst_ct", 80'(bus.ciphertext), 80'(0));
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      check("model_vec", 80'(present80(LIT_PT[i], LIT_KEY[i])), 80'(LIT_CT[i]));
      check("pkg_vec", 80'(present80(TEST_VEC[i].pt, TEST_VEC[i].key)), 80'(LIT_CT[i]));
    end

    // Directed vectors, inputs scrambled every cycle while busy.
    for (int i = 0; i < 4; i++) run_block(LIT_PT[i], LIT_KEY[i], LIT_CT[i]);

    // A second start in the middle of a block is ignored.
    drive(1'b1, '1, '1);
    @(negedge clk);
    drive(1'b0, '1, '1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) drive(1'b1, '0, '0);
      else if (cyc == 11) drive(1'b0, '0, '0);
    end while (!bus.done && cyc < 40);
    check("ignore_latency", 80'(cyc), 80'(ROUNDS));
    check("ignore_ct", 80'(bus.ciphertext), 80'(64'h3333DCD3213210D2));

    // Reset in the middle of a block aborts it immediately.
    drive(1'b1, '0, '1);
    @(negedge clk);
    drive(1'b0, '0, '1);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 80'(bus.busy), 80'(0));
    check("abort_done", 80'(bus.done), 80'(0));
    check("abort_ct", 80'(bus.ciphertext), 80'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, '0, '0);
    @(negedge clk);
    drive(1'b0, '0, '0);
    wait_done(1'b0, cyc);
    check("post_rst_latency", 80'(cyc), 80'(ROUNDS));
    check("post_rst_ct", 80'(bus.ciphertext), 80'(64'h5579C1387B228445));

    // Back-to-back: start held high, one block per 32 cycles, results in order.
    drive(1'b1, LIT_PT[0], LIT_KEY[0]);
    @(negedge clk);
    drive(1'b1, LIT_PT[1], LIT_KEY[1]);
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b0, cyc);
      check("b2b_gap", 80'(cyc), 80'(ROUNDS));
      check("b2b_ct", 80'(bus.ciphertext), 80'(LIT_CT[k]));
      @(negedge clk);
      if (k < 2) drive(1'b1, LIT_PT[k+2], LIT_KEY[k+2]);
      else drive(1'b0, '0, '0);
    end

    // Random traffic with occasional asynchronous reset pulses.
    n_rand_done = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (bus.done) n_rand_done++;
      drive($urandom_range(0, 3) == 0, {$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    check("rand_blocks_completed", 80'(n_rand_done >= 5), 80'(1));

    drive(1'b0, '0, '0);
    repeat (40) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
